// File: rtl/uart_imem_loader.sv
// UART (8N1) program loader: receives a length-prefixed little-endian image and
// writes it word-by-word into instruction memory, then raises load_done.
module uart_imem_loader #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned MAX_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [31:0] byte_address,
    output logic        write_enable,
    output logic [31:0] write_data,
    output logic        load_active,
    output logic        load_done,
    output logic        load_error
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int          CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_DONE, L_ERROR} ld_state_e;

    // Synchronizer presets to the idle (high) level so reset never looks like a start bit.
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic start_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign start_edge = rx_prev_q && !rx_sync_q;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    rx_valid_d  = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                    // A start edge coinciding with stop acceptance is not lost.
                    rx_state_d  = start_edge ? RX_START : RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    ld_state_e   ld_state_q, ld_state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] len_q, len_d;
    logic [29:0] word_idx_q, word_idx_d;
    logic [23:0] word_buf_q, word_buf_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q <= L_IDLE;
            byte_cnt_q <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            word_buf_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            word_buf_q <= word_buf_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    assign word_count = {shift_q, len_q[23:0]};

    always_comb begin
        ld_state_d = ld_state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        word_buf_d = word_buf_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        if (frame_err_q && ld_state_q != L_DONE) begin
            ld_state_d = L_ERROR;
        end else if (rx_valid_q) begin
            case (ld_state_q)
                L_IDLE: begin
                    len_d      = {24'd0, shift_q};
                    byte_cnt_d = 2'd1;
                    ld_state_d = L_LEN;
                end
                L_LEN: begin
                    case (byte_cnt_q)
                        2'd1:    len_d[15:8]  = shift_q;
                        2'd2:    len_d[23:16] = shift_q;
                        default: len_d        = word_count;
                    endcase
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        word_idx_d = '0;
                        if (word_count == 32'd0)
                            ld_state_d = L_DONE;
                        else if (word_count > 32'(MAX_WORDS))
                            ld_state_d = L_ERROR;
                        else
                            ld_state_d = L_DATA;
                    end
                end
                L_DATA: begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    case (byte_cnt_q)
                        2'd0: word_buf_d[7:0]   = shift_q;
                        2'd1: word_buf_d[15:8]  = shift_q;
                        2'd2: word_buf_d[23:16] = shift_q;
                        default: begin
                            wdata_d    = {shift_q, word_buf_q};
                            addr_d     = {word_idx_q, 2'b00};
                            we_d       = 1'b1;
                            word_idx_d = word_idx_q + 1'b1;
                            if ({2'b00, word_idx_q} == len_q - 32'd1)
                                ld_state_d = L_DONE;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign byte_address = addr_q;
    assign write_data   = wdata_q;
    assign write_enable = we_q;
    assign load_active  = (ld_state_q == L_LEN) || (ld_state_q == L_DATA);
    assign load_done    = (ld_state_q == L_DONE);
    assign load_error   = (ld_state_q == L_ERROR);
endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed + randomized bench for uart_imem_loader, checked against a byte-stream model.
module tb_uart_imem_loader;
    localparam int CPB  = 16;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] byte_address, write_data;
    logic        write_enable, load_active, load_done, load_error;

    uart_imem_loader #(
        .CLK_FREQ_HZ(1_600_000),
        .BAUD_RATE  (100_000),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .byte_address(byte_address),
        .write_enable(write_enable),
        .write_data  (write_data),
        .load_active (load_active),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] got_q[$];
    int          we_run  = 0;
    int          we_long = 0;

    always @(negedge clk) begin
        if (write_enable) begin
            got_q.push_back({byte_address, write_data});
            we_run++;
            if (we_run > 1) we_long++;
        end else begin
            we_run = 0;
        end
    end

    logic [7:0]  tx_q[$];
    int          bad_idx;
    logic [63:0] exp_q[$];
    bit          exp_done, exp_err;

    // Reference: interpret the byte stream as [N (4 bytes LE)] + N words (LE).
    function automatic void model();
        logic [31:0] n;
        int j, w;
        n = '0;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (exp_done || exp_err) break;
            if (i == bad_idx) begin
                exp_err = 1;
                break;
            end
            if (i < 4) begin
                n[8*i +: 8] = tx_q[i];
                if (i == 3) begin
                    if (n == 0) exp_done = 1;
                    else if (n > MAXW) exp_err = 1;
                end
            end else begin
                j = i - 4;
                w = j / 4;
                if (j % 4 == 3) begin
                    exp_q.push_back({32'(4 * w), tx_q[i], tx_q[i-1], tx_q[i-2], tx_q[i-3]});
                    if (w == int'(n) - 1) exp_done = 1;
                end
            end
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_ok;
        tick(CPB);
        uart_rx = 1'b1;
    endtask

    // gap_mode 0: strictly back-to-back bytes; 1: random idle gaps (often zero).
    task automatic send_range(input int first, input int last, input int gap_mode);
        int gap;
        for (int i = first; i <= last; i++) begin
            send_byte(tx_q[i], i != bad_idx);
            gap = (gap_mode == 0 || $urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            if (gap > 0) tick(gap);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " addr"},   byte_address, 32'd0);
        chk({tag, " wdata"},  write_data,   32'd0);
        chk({tag, " we"},     32'(write_enable), 32'd0);
        chk({tag, " active"}, 32'(load_active),  32'd0);
        chk({tag, " done"},   32'(load_done),    32'd0);
        chk({tag, " error"},  32'(load_error),   32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uart_rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        got_q.delete();
        we_long = 0;
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, " nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s w%0d addr", tag, i), got_q[i][63:32], exp_q[i][63:32]);
            chk($sformatf("%s w%0d data", tag, i), got_q[i][31:0],  exp_q[i][31:0]);
        end
        chk({tag, " done"},   32'(load_done),   32'(exp_done));
        chk({tag, " error"},  32'(load_error),  32'(exp_err));
        chk({tag, " active"}, 32'(load_active), 32'(!exp_done && !exp_err && tx_q.size() > 0));
        chk({tag, " strobe1"}, 32'(we_long), 32'd0);
    endtask

    task automatic run_image(input string tag, input int gap_mode);
        model();
        send_range(0, tx_q.size() - 1, gap_mode);
        tick(2 * CPB);
        compare(tag);
    endtask

    task automatic make_image(input int n);
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(8'((n >> (8 * i)) & 255));
        for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        bad_idx = -1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bad_idx = -1;
        tick(2);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick(3);
        got_q.delete();

        // T1: two-word image from fixed bytes
        tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
        bad_idx = -1;
        run_image("T1", 1);
        if (got_q.size() == 2) begin
            chk("T1 data0", got_q[0][31:0], 32'h0000_0013);
            chk("T1 data1", got_q[1][31:0], 32'h0010_0093);
        end else begin
            chk("T1 count", 32'(got_q.size()), 32'd2);
        end

        // T2: zero-length image
        do_reset();
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        bad_idx = -1;
        model();
        send_range(0, 2, 1);
        chk("T2 done early", 32'(load_done), 32'd0);
        chk("T2 active", 32'(load_active), 32'd1);
        send_range(3, 3, 0);
        chk("T2 done after 4th", 32'(load_done), 32'd1);
        tick(CPB);
        compare("T2");

        // T3: oversize length, then trailing bytes must be ignored
        do_reset();
        make_image(MAXW + 1);
        tx_q = tx_q[0:11];
        run_image("T3", 1);

        // N == MAX_WORDS, strictly back-to-back bytes
        do_reset();
        make_image(MAXW);
        run_image("TMAX", 0);

        // T4: framing error on second data byte
        do_reset();
        make_image(1);
        bad_idx = 5;
        run_image("T4", 1);

        // T5: short low glitch before a valid image
        do_reset();
        uart_rx = 1'b0;
        tick(5);
        uart_rx = 1'b1;
        tick(3 * CPB);
        chk("T5 glitch active", 32'(load_active), 32'd0);
        chk("T5 glitch error",  32'(load_error),  32'd0);
        make_image(1);
        run_image("T5", 1);

        // T6: reset in the middle of an N=2 load, then a fresh N=1 image
        do_reset();
        make_image(2);
        send_range(0, 5, 1);
        tick(CPB);
        chk("T6 mid active", 32'(load_active), 32'd1);
        chk("T6 mid nwrites", 32'(got_q.size()), 32'd0);
        #3 rst_n = 1'b0;
        #2 check_outputs_zero("T6 in reset");
        tick(3);
        rst_n = 1'b1;
        tick(3);
        got_q.delete();
        we_long = 0;
        make_image(1);
        run_image("T6", 1);

        // Random images of random size with random gaps
        for (int r = 0; r < 4; r++) begin
            do_reset();
            make_image($urandom_range(1, MAXW));
            run_image($sformatf("RND%0d", r), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
